// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: FSM state encoding
// and the register-file geometry constants.
package regfile_dump_reader_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_CNT_W    = 6;
  localparam int RF_NUM_REGS = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_CKSUM = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: walks a wrapping range of register indices via a
// dedicated read port and streams the values over a valid/ready link.
// Optional feature macro REGDUMP_CHECKSUM_EN appends an XOR checksum word
// (OutIndex=0, OutLast=1) after the last register word.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int CNT_W  = RF_CNT_W
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] StartReg,
  input  logic [CNT_W-1:0]  Count,
  output logic [ADDR_W-1:0] ReadReg,
  input  logic [DATA_W-1:0] ReadData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData,
  output logic [ADDR_W-1:0] OutIndex,
  output logic              OutLast,
  output logic              Busy,
  output logic              Done
);

  // Number of registers in the file; the package constant covers the default geometry.
  localparam int NUM_REGS = (ADDR_W == RF_ADDR_W) ? RF_NUM_REGS : (1 << ADDR_W);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_REGS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
`endif

  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
    return (c > MAX_CNT) ? MAX_CNT : c;
  endfunction

  // Next-state and next-output logic for the dump walker.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
`ifdef REGDUMP_CHECKSUM_EN
    acc_d       = acc_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (Count != '0) begin
            ptr_d   = StartReg;
            rem_d   = clamp_count(Count);
`ifdef REGDUMP_CHECKSUM_EN
            acc_d   = '0;
`endif
            state_d = ST_FETCH;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FETCH: begin
        if (Abort) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          out_data_d  = ReadData;
          out_index_d = ptr_q;
          out_valid_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
          out_last_d  = 1'b0;
`else
          out_last_d  = (rem_q == CNT_W'(1));
`endif
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (Abort) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ST_IDLE;
        end else if (OutReady) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          ptr_d       = ptr_q + ADDR_W'(1);
          rem_d       = rem_q - CNT_W'(1);
`ifdef REGDUMP_CHECKSUM_EN
          acc_d       = acc_q ^ out_data_q;
`endif
          if (rem_q > CNT_W'(1)) begin
            state_d = ST_FETCH;
          end else begin
`ifdef REGDUMP_CHECKSUM_EN
            // Checksum word goes out directly, including the word just accepted.
            out_data_d  = acc_q ^ out_data_q;
            out_index_d = '0;
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
            state_d     = ST_CKSUM;
`else
            state_d     = ST_FIN;
`endif
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      ST_CKSUM: begin
        if (Abort) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ST_IDLE;
        end else if (OutReady) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ST_FIN;
        end
      end
`endif
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    done_d = (state_d == ST_FIN);
  end

  // State and registered outputs; reset clears everything, including data.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
`ifdef REGDUMP_CHECKSUM_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign ReadReg  = ptr_q;
  assign OutValid = out_valid_q;
  assign OutData  = out_data_q;
  assign OutIndex = out_index_q;
  assign OutLast  = out_last_q;
  assign Done     = done_q;
  assign Busy     = (state_q != ST_IDLE);

endmodule
